// File: rtl/pulse_freq_counter_32ch.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_freq_counter_32ch
//  Description : Per-channel rising-edge counter over a programmable gate
//                window. All channel counts are snapshotted at window end and
//                streamed out as NCH words over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_freq_counter_32ch #(
   parameter int NCH   = 32,
   parameter int CNT_W = 24,
   parameter int OVR_W = 16
) (
   input  logic                     clk_20m,
   input  logic                     rst,
   input  logic [NCH-1:0]           pulse_in,
   input  logic                     meas_en,
   input  logic [31:0]              gate_len,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(NCH)-1:0]   out_ch,
   output logic [CNT_W-1:0]         out_cnt,
   output logic                     out_last,
   output logic [OVR_W-1:0]         ovr_cnt
);

   localparam int               IDX_W    = $clog2(NCH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [OVR_W-1:0] OVR_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Edge detect and gate window
   // ---------------------------------------------------------------------
   logic [NCH-1:0] prev_in_q;
   logic [NCH-1:0] rise;
   logic [31:0]    gate_cnt_q, gate_cnt_d;
   logic [31:0]    gate_len_q, gate_len_d;
   logic [31:0]    gate_eff;
   logic           win_start;
   logic           win_end;

   // Rising edges, window start/end detection and gate counter next value.
   // gate_len is captured on the first cycle of each window; the fresh value
   // already governs that cycle so a one-cycle window ends immediately.
   always_comb begin
      rise       = pulse_in & ~prev_in_q;
      win_start  = meas_en && (gate_cnt_q == 32'd0);
      gate_len_d = gate_len_q;
      if (win_start) begin
         gate_len_d = (gate_len == 32'd0) ? 32'd1 : gate_len;
      end
      gate_eff   = win_start ? gate_len_d : gate_len_q;
      win_end    = meas_en && (gate_cnt_q == (gate_eff - 32'd1));
      gate_cnt_d = 32'd0;
      if (meas_en && !win_end) begin
         gate_cnt_d = gate_cnt_q + 32'd1;
      end
   end

   // Edge history runs regardless of meas_en; reset to ones so a line held
   // high across reset release is not mistaken for an edge.
   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         prev_in_q  <= '1;
         gate_cnt_q <= 32'd0;
         gate_len_q <= 32'd0;
      end else begin
         prev_in_q  <= pulse_in;
         gate_cnt_q <= gate_cnt_d;
         gate_len_q <= gate_len_d;
      end
   end

   // ---------------------------------------------------------------------
   // Per-channel saturating counters
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q     [NCH];
   logic [CNT_W-1:0] cnt_d     [NCH];
   logic [CNT_W-1:0] frame_val [NCH];

   // frame_val includes the edge of the current cycle, so an edge on the
   // window end cycle lands in the closing frame.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         if (cnt_q[i] == CNT_MAX) begin
            frame_val[i] = CNT_MAX;
         end else begin
            frame_val[i] = cnt_q[i] + CNT_W'(rise[i]);
         end
         cnt_d[i] = (meas_en && !win_end) ? frame_val[i] : '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Readout FSM with shadow snapshot
   // ---------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] shadow_q [NCH];
   logic [CNT_W-1:0] shadow_d [NCH];
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] idx_nxt;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_last_q, out_last_d;
   logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
   logic             accept;

   // Next-state and output-register logic; a window end while a frame is
   // still being sent (including on its final accept) is dropped and counted.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      idx_d      = idx_q;
      out_cnt_d  = out_cnt_q;
      out_last_d = out_last_q;
      ovr_cnt_d  = ovr_cnt_q;
      accept     = (state_q == ST_SEND) && out_ready;
      idx_nxt    = idx_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (win_end) begin
               state_d    = ST_SEND;
               shadow_d   = frame_val;
               idx_d      = '0;
               out_cnt_d  = frame_val[0];
               out_last_d = (NCH == 1);
            end
         end
         ST_SEND: begin
            if (win_end && (ovr_cnt_q != OVR_MAX)) begin
               ovr_cnt_d = ovr_cnt_q + 1'b1;
            end
            if (accept) begin
               if (idx_q == IDX_LAST) begin
                  state_d    = ST_IDLE;
                  idx_d      = '0;
                  out_cnt_d  = '0;
                  out_last_d = 1'b0;
               end else begin
                  idx_d      = idx_nxt;
                  out_cnt_d  = shadow_q[idx_nxt];
                  out_last_d = (idx_nxt == IDX_LAST);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, shadow and output registers.
   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         out_cnt_q  <= '0;
         out_last_q <= 1'b0;
         ovr_cnt_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         out_cnt_q  <= out_cnt_d;
         out_last_q <= out_last_d;
         ovr_cnt_q  <= ovr_cnt_d;
         for (int i = 0; i < NCH; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign out_valid = (state_q == ST_SEND);
   assign out_ch    = idx_q;
   assign out_cnt   = out_cnt_q;
   assign out_last  = out_last_q;
   assign ovr_cnt   = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_freq_counter_32ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_freq_counter_32ch
//  Description : Scoreboard bench for pulse_freq_counter_32ch (CNT_W = 4 so
//                saturation is reachable in a short window).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_freq_counter_32ch;

   localparam int NCH   = 32;
   localparam int CNT_W = 4;
   localparam int OVR_W = 16;

   logic              clk_20m   = 1'b0;
   logic              rst       = 1'b1;
   logic [NCH-1:0]    pulse_in  = '0;
   logic              meas_en   = 1'b0;
   logic [31:0]       gate_len  = 32'd100;
   logic              out_ready = 1'b1;
   logic              out_valid;
   logic [4:0]        out_ch;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_last;
   logic [OVR_W-1:0]  ovr_cnt;

   pulse_freq_counter_32ch #(
      .NCH   (NCH),
      .CNT_W (CNT_W),
      .OVR_W (OVR_W)
   ) dut (
      .clk_20m   (clk_20m),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .meas_en   (meas_en),
      .gate_len  (gate_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_cnt   (out_cnt),
      .out_last  (out_last),
      .ovr_cnt   (ovr_cnt)
   );

   always #25 clk_20m = ~clk_20m;

   typedef struct packed {
      logic [4:0]       ch;
      logic [CNT_W-1:0] cnt;
      logic             last;
   } word_t;

   word_t            exp_q[$];
   word_t            mon_w;
   logic [CNT_W-1:0] exp_cnt [NCH];
   int               checks   = 0;
   int               failures = 0;

   task automatic tick();
      @(posedge clk_20m);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NCH; i++) exp_cnt[i] = '0;
   endtask

   // Queue the first n words of a frame built from exp_cnt.
   task automatic push_words(input int n);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w.ch   = 5'(i);
         w.cnt  = exp_cnt[i];
         w.last = (i == NCH - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s: words_left=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      tick();
      tick();
   endtask

   // Monitor: every accepted word is compared against the scoreboard head.
   always @(negedge clk_20m) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_word: actual ch=%0d cnt=%0d last=%0d required=no word",
                     out_ch, out_cnt, out_last);
         end else begin
            mon_w = exp_q.pop_front();
            if (out_ch !== mon_w.ch || out_cnt !== mon_w.cnt || out_last !== mon_w.last) begin
               failures++;
               $display("FAIL word: actual ch=%0d cnt=%0d last=%0d required ch=%0d cnt=%0d last=%0d",
                        out_ch, out_cnt, out_last, mon_w.ch, mon_w.cnt, mon_w.last);
            end
         end
      end
   end

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_ch",    out_ch,    0);
      check("rst_cnt",   out_cnt,   0);
      check("rst_last",  out_last,  0);
      check("rst_ovr",   ovr_cnt,   0);
      rst = 1'b0;
      tick();

      // T1: five single-cycle pulses on ch 3 in a 100-cycle window
      clear_exp(); exp_cnt[3] = 4'd5; push_words(NCH);
      meas_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         pulse_in = '0;
         pulse_in[3] = (c >= 10 && c <= 50 && (c % 10) == 0);
         tick();
      end
      pulse_in = '0; meas_en = 1'b0;
      drain("t1_drain");

      // T2: ch 0 held high across window end; ch 1 edge on the end cycle
      clear_exp(); exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd1; push_words(NCH);
      clear_exp(); push_words(NCH);
      meas_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         pulse_in = '0;
         pulse_in[0] = (c >= 50 && c <= 150);
         pulse_in[1] = (c == 99);
         tick();
      end
      pulse_in = '0; meas_en = 1'b0;
      drain("t2_drain");

      // T3: 20 edges on ch 7 saturate at 15; next window restarts from 0
      clear_exp(); exp_cnt[7] = 4'd15; push_words(NCH);
      clear_exp(); exp_cnt[7] = 4'd3;  push_words(NCH);
      meas_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         pulse_in = '0;
         pulse_in[7] = (c >= 2 && c <= 40 && (c % 2) == 0) || c == 110 || c == 112 || c == 114;
         tick();
      end
      pulse_in = '0; meas_en = 1'b0;
      drain("t3_drain");

      // T4: backpressure with gate 50; four later windows end while sending
      gate_len = 32'd50; out_ready = 1'b0;
      clear_exp(); exp_cnt[0] = 4'd3; push_words(NCH);
      meas_en = 1'b1;
      for (int c = 0; c < 250; c++) begin
         pulse_in = '0;
         pulse_in[0] = (c == 10 || c == 20 || c == 30 || c == 60 || c == 70);
         tick();
         if (c == 100 || c == 240) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_ch",    out_ch,    0);
            check("t4_hold_cnt",   out_cnt,   3);
            check("t4_hold_last",  out_last,  0);
         end
         if (c == 100) check("t4_ovr_first", ovr_cnt, 1);
      end
      check("t4_ovr_cnt", ovr_cnt, 4);
      pulse_in = '0; meas_en = 1'b0; out_ready = 1'b1;
      drain("t4_drain");

      // T5: abort at gate_cnt 40, then only post-re-enable edges count
      gate_len = 32'd100;
      clear_exp(); exp_cnt[9] = 4'd2; push_words(NCH);
      meas_en = 1'b1;
      for (int c = 0; c < 40; c++) begin
         pulse_in = '0;
         pulse_in[9] = (c == 10 || c == 20);
         tick();
      end
      meas_en = 1'b0;
      for (int c = 40; c < 60; c++) begin
         pulse_in = '0;
         pulse_in[9]  = (c == 50);
         pulse_in[10] = (c >= 55);
         tick();
      end
      check("t5_abort_valid", out_valid, 0);
      meas_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         pulse_in = '0;
         pulse_in[9]  = (c == 30 || c == 50);
         pulse_in[10] = 1'b1;
         tick();
      end
      pulse_in = '0; meas_en = 1'b0;
      drain("t5_drain");

      // T6: reset while word ch 10 is presented
      clear_exp(); exp_cnt[0] = 4'd1; push_words(10);
      meas_en = 1'b1;
      for (int c = 0; c < 110; c++) begin
         pulse_in = '0;
         pulse_in[0] = (c == 5);
         tick();
      end
      check("t6_pre_valid", out_valid, 1);
      check("t6_pre_ch",    out_ch,    10);
      pulse_in = '0; pulse_in[4] = 1'b1;
      rst = 1'b1;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_last",  out_last,  0);
      check("t6_rst_ovr",   ovr_cnt,   0);
      check("t6_rst_ch",    out_ch,    0);
      check("t6_words_left", exp_q.size(), 0);
      tick();
      tick();
      clear_exp(); exp_cnt[4] = 4'd1; push_words(NCH);
      rst = 1'b0; meas_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         pulse_in = '0;
         pulse_in[4] = !(c >= 50 && c < 60);
         tick();
      end
      pulse_in = '0; meas_en = 1'b0;
      drain("t6_drain");
      check("t6_final_ovr", ovr_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
